// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader into instruction memory that holds the CPU in reset until loaded
module imem_loader #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_valid,
  input  logic [7:0]          ld_data,
  input  logic                ld_last,
  output logic                ld_ready,
  input  logic                reload,
  input  logic [ADDRSIZE-1:0] ins_addr,
  output logic [0:WIDTH-1]    ins_data,
  output logic                cpu_rst,
  output logic [ADDRSIZE:0]   words_loaded,
  output logic                err_partial,
  output logic                err_ovf
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state;
  logic [0:WIDTH-1] mem [0:2**ADDRSIZE-1];
  logic [0:WIDTH-1] asm_word, word_nxt;
  logic [ADDRSIZE-1:0] wr_addr;
  logic [1:0] bcnt;
  logic acc, wr, full;
  assign ld_ready = state != RUN;
  assign acc = ld_valid && ld_ready;
  assign wr = acc && (bcnt == 2'd3 || ld_last);
  assign full = &wr_addr;
  // asm_word is kept zero past the current byte, so a short final word is zero-padded for free
  assign word_nxt = asm_word | (WIDTH'(ld_data) << (8 * (3 - int'(bcnt))));
  assign cpu_rst = rst || state != RUN;
  assign ins_data = state == RUN ? mem[ins_addr] : '0;
  always_ff @(posedge clk)
    if (wr) mem[wr_addr] <= word_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      wr_addr      <= '0;
      bcnt         <= '0;
      asm_word     <= '0;
      words_loaded <= '0;
      err_partial  <= 1'b0;
      err_ovf      <= 1'b0;
    end else if (state == RUN) begin
      if (reload) begin
        state        <= IDLE;
        wr_addr      <= '0;
        bcnt         <= '0;
        asm_word     <= '0;
        words_loaded <= '0;
        err_partial  <= 1'b0;
        err_ovf      <= 1'b0;
      end
    end else if (acc) begin
      state    <= LOAD;
      bcnt     <= bcnt + 2'd1;
      asm_word <= wr ? '0 : word_nxt;
      if (wr) begin
        words_loaded <= words_loaded[ADDRSIZE] ? words_loaded : words_loaded + 1'b1;
        if (!full) wr_addr <= wr_addr + 1'b1;
        if (ld_last) begin
          state       <= RUN;
          bcnt        <= '0;
          err_partial <= bcnt != 2'd3;
        end else if (full) begin
          state   <= RUN;
          err_ovf <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads checked against a byte-stream reference model
module tb_imem_loader;
  localparam int AW = 12;
  localparam int DEPTH = 1 << AW;
  logic clk = 0, rst = 1, ld_valid = 0, ld_last = 0, reload = 0;
  logic [7:0] ld_data = 0;
  logic [AW-1:0] ins_addr = 0;
  logic ld_ready, cpu_rst, err_partial, err_ovf;
  logic [0:31] ins_data;
  logic [AW:0] words_loaded;
  int vectors = 0, miscompares = 0;
  logic [31:0] exp_mem [DEPTH];
  bit known [DEPTH];
  logic [31:0] pend;
  int nbytes, exp_wl;
  bit exp_part, exp_ovf, exp_run;

  imem_loader #(.WIDTH(32), .ADDRSIZE(AW)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .reload(reload), .ins_addr(ins_addr), .ins_data(ins_data),
    .cpu_rst(cpu_rst), .words_loaded(words_loaded), .err_partial(err_partial), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    nbytes = 0; pend = 0; exp_wl = 0; exp_part = 0; exp_ovf = 0; exp_run = 0;
  endtask

  // big-endian packing; a word commits on its 4th byte or on the last byte
  task automatic model_byte(input logic [7:0] d, input bit last);
    int k;
    k = nbytes % 4;
    pend[31-8*k -: 8] = d;
    nbytes++;
    if (k == 3 || last) begin
      exp_mem[exp_wl] = pend;
      known[exp_wl] = 1;
      exp_wl++;
      pend = 0;
    end
    exp_part = last && (nbytes % 4 != 0);
    exp_ovf = !last && exp_wl == DEPTH;
    exp_run = last || exp_wl == DEPTH;
  endtask

  task automatic send(input logic [7:0] d, input bit last, input bit gap);
    if (gap) begin
      ld_valid = 0; ld_data = 8'($urandom); ld_last = 1'($urandom); reload = 1'($urandom);
      tick;
    end
    ld_valid = 1; ld_data = d; ld_last = last; reload = 1'($urandom);
    tick;
    ld_valid = 0; ld_last = 0; reload = 0;
    model_byte(d, last);
  endtask

  task automatic check_status(input string tag);
    check({tag, ".ld_ready"}, 32'(ld_ready), 32'(!exp_run));
    check({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(!exp_run));
    check({tag, ".words_loaded"}, 32'(words_loaded), 32'(exp_wl));
    check({tag, ".err_partial"}, 32'(err_partial), 32'(exp_part));
    check({tag, ".err_ovf"}, 32'(err_ovf), 32'(exp_ovf));
  endtask

  task automatic check_mem(input int lo, input int hi);
    for (int a = lo; a <= hi; a++)
      if (known[a]) begin
        ins_addr = AW'(a);
        #1;
        check($sformatf("rd[%0d]", a), ins_data, exp_run ? exp_mem[a] : 32'h0);
      end
  endtask

  task automatic do_reload;
    reload = 1;
    tick;
    reload = 0;
    model_clear;
    check("reload.cpu_rst", 32'(cpu_rst), 32'h1);
    check("reload.nop", ins_data, 32'h0);
    check_status("reload");
  endtask

  initial begin
    logic [7:0] prog [8];
    int n;
    for (int a = 0; a < DEPTH; a++) known[a] = 0;
    model_clear;
    tick;
    tick;
    check("rst.ld_ready", 32'(ld_ready), 32'h1);
    check("rst.cpu_rst", 32'(cpu_rst), 32'h1);
    check("rst.ins_data", ins_data, 32'h0);
    check("rst.words_loaded", 32'(words_loaded), 32'h0);
    check("rst.errs", {30'h0, err_partial, err_ovf}, 32'h0);
    rst = 0;
    tick;
    check_status("idle");

    prog = '{8'h40, 8'h00, 8'h10, 8'h01, 8'h90, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("basic.cpu_rst_before_last", 32'(cpu_rst), 32'h1);
      send(prog[i], i == 7, 0);
    end
    check_status("basic");
    ins_addr = 0; #1; check("basic.w0", ins_data, 32'h40001001);
    ins_addr = 1; #1; check("basic.w1", ins_data, 32'h90000000);

    do_reload;
    send(8'h12, 0, 0); send(8'h34, 0, 0); send(8'h56, 1, 0);
    check_status("partial");
    ins_addr = 0; #1; check("partial.w0", ins_data, 32'h12345600);
    check_mem(0, 3);

    do_reload;
    for (int i = 0; i < 8; i++) send(8'($urandom), i == 7, 1);
    check_status("gaps");
    check_mem(0, 3);

    do_reload;
    send(8'h10, 0, 0); send(8'h00, 0, 0); send(8'h00, 0, 0); send(8'h05, 1, 0);
    check_status("reload1");
    ins_addr = 0; #1; check("reload1.w0", ins_data, 32'h10000005);
    check_mem(0, 3);

    repeat (20) begin
      do_reload;
      n = $urandom_range(1, 60);
      for (int i = 0; i < n; i++) send(8'($urandom), i == n - 1, 1'($urandom));
      check_status("rand");
      check_mem(0, 20);
    end

    do_reload;
    send(8'hAA, 0, 0); send(8'hBB, 0, 0);
    #2 rst = 1;
    #1;
    check("rstmid.cpu_rst", 32'(cpu_rst), 32'h1);
    check("rstmid.ld_ready", 32'(ld_ready), 32'h1);
    check("rstmid.words_loaded", 32'(words_loaded), 32'h0);
    tick;
    rst = 0;
    model_clear;
    check_status("rstmid.idle");
    send(8'hC1, 0, 0); send(8'hC2, 0, 0); send(8'hC3, 0, 0); send(8'hC4, 1, 0);
    check_status("rstmid.reload");
    ins_addr = 0; #1; check("rstmid.w0", ins_data, 32'hC1C2C3C4);
    check_mem(0, 20);

    do_reload;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (i == 4 * DEPTH - 1) begin
        check("ovf.ready_before_end", 32'(ld_ready), 32'h1);
        check("ovf.wl_before_end", 32'(words_loaded), 32'(DEPTH - 1));
      end
      send(8'($urandom), 0, 0);
    end
    check_status("ovf");
    ins_addr = 0; #1; check("ovf.w0", ins_data, exp_mem[0]);
    ld_valid = 1; ld_data = 8'h77; ld_last = 1;
    tick;
    ld_valid = 0; ld_last = 0;
    check_status("ovf.extra");
    check_mem(0, DEPTH - 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
